toaplan2_cen_sched: RTL and testbench

- Runtime-configurable scheduler for the fractional clock enables that pace the video (GP9001), YM2151 and OKI datapaths.
- Holds NCH independent n/m fractional accumulators clocked by CLK96.
- Per-game rate configuration is loaded over a small write port and applied glitch-free at each channel's next period boundary.
- Audio pause gates a masked subset of channels without emitting partial pulses.

---
 rtl/toaplan2_cen_sched.sv | 161 ++++++++++++++++
 tb/tb_toaplan2_cen_sched.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/toaplan2_cen_sched.sv
// NCH-channel n/m fractional clock-enable scheduler on CLK96 with glitch-free reconfig and pause.
// Optional per-channel CEN pulse counters are built when TOAPLAN2_CEN_COUNT_EN is defined.
module toaplan2_cen_sched #(
   parameter int unsigned        NCH     = 4,
   parameter int unsigned        W       = 10,
   parameter logic [NCH*2*W-1:0] RST_CFG = '0
) (
   input  logic                   CLK96,
   input  logic                   RESET,
   input  logic                   CFG_WE,
   input  logic [$clog2(NCH)-1:0] CFG_CH,
   input  logic [W-1:0]           CFG_N,
   input  logic [W-1:0]           CFG_M,
   input  logic                   PAUSE,
   input  logic [NCH-1:0]         PAUSE_MASK,
`ifdef TOAPLAN2_CEN_COUNT_EN
   input  logic [$clog2(NCH)-1:0] RD_CH,
   output logic [15:0]            RD_CNT,
`endif
   output logic [NCH-1:0]         CEN,
   output logic [NCH-1:0]         CENB,
   output logic [NCH-1:0]         PENDING,
   output logic [NCH-1:0]         CFG_ERR
);

   logic [W-1:0]   n_q   [NCH];
   logic [W-1:0]   n_d   [NCH];
   logic [W-1:0]   m_q   [NCH];
   logic [W-1:0]   m_d   [NCH];
   logic [W-1:0]   sn_q  [NCH];
   logic [W-1:0]   sn_d  [NCH];
   logic [W-1:0]   sm_q  [NCH];
   logic [W-1:0]   sm_d  [NCH];
   logic [W-1:0]   acc_q [NCH];
   logic [W-1:0]   acc_d [NCH];
   logic [W:0]     sum   [NCH];

   logic [NCH-1:0] pend_q, pend_d;
   logic [NCH-1:0] tog_q, tog_d;
   logic [NCH-1:0] cen_q, cen_d;
   logic [NCH-1:0] cenb_q, cenb_d;
   logic [NCH-1:0] valid, running, gated, pulse, apply, wr_hit;
   logic [31:0]    cfg_ch_ext;

   assign cfg_ch_ext = 32'(CFG_CH);

   always_comb begin
      for (int unsigned i = 0; i < NCH; i++) begin
         valid[i]   = (m_q[i] != '0) && (n_q[i] <= m_q[i]);
         running[i] = valid[i] && (n_q[i] != '0);
         gated[i]   = PAUSE & PAUSE_MASK[i];
         sum[i]     = {1'b0, acc_q[i]} + {1'b0, n_q[i]};
         pulse[i]   = running[i] && !gated[i] && (sum[i] >= {1'b0, m_q[i]});
         // Swap configs only where no partial period can be emitted
         apply[i]   = pend_q[i] && (pulse[i] || !running[i] || gated[i]);
         wr_hit[i]  = CFG_WE && (cfg_ch_ext == i) && (cfg_ch_ext < NCH);
      end
   end

   always_comb begin
      for (int unsigned i = 0; i < NCH; i++) begin
         n_d[i]    = n_q[i];
         m_d[i]    = m_q[i];
         sn_d[i]   = sn_q[i];
         sm_d[i]   = sm_q[i];
         acc_d[i]  = acc_q[i];
         pend_d[i] = pend_q[i];
         tog_d[i]  = tog_q[i];
         cen_d[i]  = pulse[i];
         cenb_d[i] = pulse[i] & tog_q[i];
         if (apply[i]) begin
            n_d[i]    = sn_q[i];
            m_d[i]    = sm_q[i];
            acc_d[i]  = '0;
            tog_d[i]  = 1'b0;
            pend_d[i] = 1'b0;
         end else if (running[i] && !gated[i]) begin
            acc_d[i] = pulse[i] ? W'(sum[i] - {1'b0, m_q[i]}) : W'(sum[i]);
            if (pulse[i]) begin
               tog_d[i] = ~tog_q[i];
            end
         end
         // A write landing on the apply cycle becomes the next shadow
         if (wr_hit[i]) begin
            sn_d[i]   = CFG_N;
            sm_d[i]   = CFG_M;
            pend_d[i] = 1'b1;
         end
      end
   end

   always_ff @(posedge CLK96) begin
      if (RESET) begin
         for (int unsigned i = 0; i < NCH; i++) begin
            n_q[i]   <= RST_CFG[i*2*W +: W];
            m_q[i]   <= RST_CFG[i*2*W+W +: W];
            sn_q[i]  <= '0;
            sm_q[i]  <= '0;
            acc_q[i] <= '0;
         end
         pend_q <= '0;
         tog_q  <= '0;
         cen_q  <= '0;
         cenb_q <= '0;
      end else begin
         n_q    <= n_d;
         m_q    <= m_d;
         sn_q   <= sn_d;
         sm_q   <= sm_d;
         acc_q  <= acc_d;
         pend_q <= pend_d;
         tog_q  <= tog_d;
         cen_q  <= cen_d;
         cenb_q <= cenb_d;
      end
   end

   assign CEN     = cen_q;
   assign CENB    = cenb_q;
   assign PENDING = pend_q;
   assign CFG_ERR = ~valid;

`ifdef TOAPLAN2_CEN_COUNT_EN
   logic [15:0]            cnt_q [NCH];
   logic [15:0]            cnt_d [NCH];
   logic [$clog2(NCH)-1:0] rd_ch_q;
   logic [15:0]            rd_cnt_q;
   logic [31:0]            rd_ch_ext;

   assign rd_ch_ext = 32'(RD_CH);

   always_comb begin
      for (int unsigned i = 0; i < NCH; i++) begin
         cnt_d[i] = cnt_q[i];
         if (pulse[i] && (cnt_q[i] != 16'hFFFF)) begin
            cnt_d[i] = cnt_q[i] + 16'd1;
         end
         if (apply[i] || ((RD_CH != rd_ch_q) && (rd_ch_ext == i))) begin
            cnt_d[i] = '0;
         end
      end
   end

   always_ff @(posedge CLK96) begin
      if (RESET) begin
         for (int unsigned i = 0; i < NCH; i++) begin
            cnt_q[i] <= '0;
         end
         rd_ch_q  <= '0;
         rd_cnt_q <= '0;
      end else begin
         cnt_q    <= cnt_d;
         rd_ch_q  <= RD_CH;
         rd_cnt_q <= (rd_ch_ext < NCH) ? cnt_d[RD_CH] : '0;
      end
   end

   assign RD_CNT = rd_cnt_q;
`endif

endmodule

// File: tb/tb_toaplan2_cen_sched.sv
// Bench for toaplan2_cen_sched: directed scenarios with literal expectations plus a per-cycle
// model that derives pulses from floor(k*n/m) over running steps k since the last apply.
module tb_toaplan2_cen_sched;

   localparam int unsigned NCH = 4;
   localparam int unsigned W   = 10;
   // ch3 leaves reset running n=2, m=5; ch0..ch2 leave reset disabled
   localparam logic [NCH*2*W-1:0] RST_CFG = {10'd5, 10'd2, 60'd0};

   logic           CLK96 = 1'b0;
   logic           RESET;
   logic           CFG_WE;
   logic [1:0]     CFG_CH;
   logic [W-1:0]   CFG_N;
   logic [W-1:0]   CFG_M;
   logic           PAUSE;
   logic [NCH-1:0] PAUSE_MASK;
   logic [NCH-1:0] CEN;
   logic [NCH-1:0] CENB;
   logic [NCH-1:0] PENDING;
   logic [NCH-1:0] CFG_ERR;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 CLK96 = ~CLK96;

   toaplan2_cen_sched #(
      .NCH     (NCH),
      .W       (W),
      .RST_CFG (RST_CFG)
   ) dut (
      .CLK96      (CLK96),
      .RESET      (RESET),
      .CFG_WE     (CFG_WE),
      .CFG_CH     (CFG_CH),
      .CFG_N      (CFG_N),
      .CFG_M      (CFG_M),
      .PAUSE      (PAUSE),
      .PAUSE_MASK (PAUSE_MASK),
      .CEN        (CEN),
      .CENB       (CENB),
      .PENDING    (PENDING),
      .CFG_ERR    (CFG_ERR)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [NCH*2*W-1:0] rst_v;
   assign rst_v = RST_CFG;

   int unsigned    mn [NCH];
   int unsigned    mm [NCH];
   int unsigned    sn [NCH];
   int unsigned    sm [NCH];
   bit             mpend [NCH];
   longint         mk [NCH];
   logic [NCH-1:0] e_cen, e_cenb, e_pend, e_err;
   bit             live = 1'b0;
   bit             m_run, m_gate, m_p;
   longint         m_now, m_prev;

   function automatic bit cfg_ok(input int unsigned n, input int unsigned m);
      return (m != 0) && (n <= m);
   endfunction

   initial forever begin
      @(posedge CLK96);
      if (RESET) begin
         for (int c = 0; c < NCH; c++) begin
            mn[c]     = 32'(rst_v[c*20 +: 10]);
            mm[c]     = 32'(rst_v[c*20+10 +: 10]);
            sn[c]     = 0;
            sm[c]     = 0;
            mpend[c]  = 1'b0;
            mk[c]     = 0;
            e_cen[c]  = 1'b0;
            e_cenb[c] = 1'b0;
            e_pend[c] = 1'b0;
            e_err[c]  = !cfg_ok(mn[c], mm[c]);
         end
         live = 1'b1;
      end else begin
         for (int c = 0; c < NCH; c++) begin
            m_run  = cfg_ok(mn[c], mm[c]) && (mn[c] != 0);
            m_gate = PAUSE && PAUSE_MASK[c];
            m_p    = 1'b0;
            m_now  = 0;
            if (m_run && !m_gate) begin
               mk[c]++;
               m_now  = mk[c] * mn[c] / mm[c];
               m_prev = (mk[c] - 1) * mn[c] / mm[c];
               m_p    = (m_now != m_prev);
            end
            e_cen[c]  = m_p;
            e_cenb[c] = m_p && (m_now % 2 == 0);
            if (mpend[c] && (m_p || !m_run || m_gate)) begin
               mn[c]    = sn[c];
               mm[c]    = sm[c];
               mk[c]    = 0;
               mpend[c] = 1'b0;
            end
            if (CFG_WE && (int'(CFG_CH) == c)) begin
               sn[c]    = 32'(CFG_N);
               sm[c]    = 32'(CFG_M);
               mpend[c] = 1'b1;
            end
            e_pend[c] = mpend[c];
            e_err[c]  = !cfg_ok(mn[c], mm[c]);
         end
      end
   end

   initial forever begin
      @(negedge CLK96);
      if (live) begin
         check("model_cen", 32'(CEN), 32'(e_cen));
         check("model_cenb", 32'(CENB), 32'(e_cenb));
         check("model_pending", 32'(PENDING), 32'(e_pend));
         check("model_cfg_err", 32'(CFG_ERR), 32'(e_err));
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic cfg_write(input logic [1:0] ch, input logic [W-1:0] n, input logic [W-1:0] m);
      CFG_WE = 1'b1;
      CFG_CH = ch;
      CFG_N  = n;
      CFG_M  = m;
      @(posedge CLK96);
      #1;
      CFG_WE = 1'b0;
   endtask

   // Cycles (edges) until the next CEN/CENB on ch; -1 if none within the budget
   task automatic wait_pulse(input int ch, input bit use_b, output int cyc);
      cyc = -1;
      for (int k = 1; k <= 2000; k++) begin
         @(posedge CLK96);
         @(negedge CLK96);
         if ((use_b ? CENB[ch] : CEN[ch]) == 1'b1) begin
            cyc = k;
            break;
         end
      end
   endtask

   task automatic wait_pend_clear(input int ch, output int cyc);
      cyc = -1;
      for (int k = 1; k <= 2000; k++) begin
         @(negedge CLK96);
         if (!PENDING[ch]) begin
            cyc = k;
            break;
         end
      end
   endtask

   initial begin
      int c, cnt, cntb, adj, badb;
      bit prev;
      RESET      = 1'b1;
      CFG_WE     = 1'b0;
      CFG_CH     = '0;
      CFG_N      = '0;
      CFG_M      = '0;
      PAUSE      = 1'b0;
      PAUSE_MASK = '0;
      repeat (3) @(posedge CLK96);
      @(negedge CLK96);
      check("rst_cen", 32'(CEN), 32'h0);
      check("rst_cenb", 32'(CENB), 32'h0);
      check("rst_pending", 32'(PENDING), 32'h0);
      check("rst_cfg_err", 32'(CFG_ERR), 32'h7);
      @(posedge CLK96);
      #1 RESET = 1'b0;

      // Invalid config (m=0) on ch2, then a valid 5/7 config
      cfg_write(2'd2, 10'd5, 10'd0);
      @(negedge CLK96);
      check("inv_pend_latched", 32'(PENDING[2]), 32'h1);
      @(negedge CLK96);
      check("inv_applied_next", 32'(PENDING[2]), 32'h0);
      check("inv_cfg_err", 32'(CFG_ERR[2]), 32'h1);
      cnt = 0;
      repeat (20) begin
         @(negedge CLK96);
         if (CEN[2]) cnt++;
      end
      check("inv_no_cen", 32'(cnt), 32'd0);
      cfg_write(2'd2, 10'd5, 10'd7);
      @(negedge CLK96);
      @(negedge CLK96);
      check("r57_cfg_err_clear", 32'(CFG_ERR[2]), 32'h0);
      check("r57_applied_next", 32'(PENDING[2]), 32'h0);
      for (int blk = 0; blk < 2; blk++) begin
         cnt = 0;
         repeat (7) begin
            @(posedge CLK96);
            @(negedge CLK96);
            if (CEN[2]) cnt++;
         end
         check("r57_five_per_seven", 32'(cnt), 32'd5);
      end

      // ch0 9/320 over 3200 running steps
      cfg_write(2'd0, 10'd9, 10'd320);
      @(posedge CLK96);
      cnt = 0; cntb = 0; adj = 0; badb = 0; prev = 1'b0;
      repeat (3200) begin
         @(posedge CLK96);
         @(negedge CLK96);
         if (CEN[0]) cnt++;
         if (CENB[0]) cntb++;
         if (CEN[0] && prev) adj++;
         if (CENB[0] && !CEN[0]) badb++;
         prev = CEN[0];
      end
      check("r9_320_cen_count", 32'(cnt), 32'd90);
      check("r9_320_cenb_count", 32'(cntb), 32'd45);
      check("r9_320_adjacent", 32'(adj), 32'd0);
      check("r9_320_cenb_subset", 32'(badb), 32'd0);

      // ch1 1/29: strobe edge + apply edge + 29 cycles
      cfg_write(2'd1, 10'd1, 10'd29);
      wait_pulse(1, 1'b0, c);
      check("r1_29_first_cen", 32'(c), 32'd30);
      check("r1_29_first_no_cenb", 32'(CENB[1]), 32'h0);
      wait_pulse(1, 1'b0, c);
      check("r1_29_period", 32'(c), 32'd29);
      check("r1_29_second_cenb", 32'(CENB[1]), 32'h1);
      wait_pulse(1, 1'b1, c);
      check("r1_29_cenb_period", 32'(c), 32'd58);

      // ch0 retune 1/29 -> 1/10 mid-period
      cfg_write(2'd0, 10'd1, 10'd29);
      wait_pend_clear(0, c);
      check("retune_first_apply_seen", 32'(c > 0), 32'h1);
      wait_pulse(0, 1'b0, c);
      check("retune_first_period", 32'(c), 32'd29);
      repeat (4) @(negedge CLK96);
      cfg_write(2'd0, 10'd1, 10'd10);
      cnt = 0;
      for (int k = 0; k < 200; k++) begin
         @(negedge CLK96);
         if (PENDING[0]) cnt++;
         else break;
      end
      check("retune_pending_cycles", 32'(cnt), 32'd24);
      check("retune_apply_on_pulse", 32'(CEN[0]), 32'h1);
      wait_pulse(0, 1'b0, c);
      check("retune_new_period_a", 32'(c), 32'd10);
      wait_pulse(0, 1'b0, c);
      check("retune_new_period_b", 32'(c), 32'd10);

      // ch2 1/29 paused at acc=17 for 100 cycles
      cfg_write(2'd2, 10'd1, 10'd29);
      wait_pend_clear(2, c);
      check("pause_apply_seen", 32'(c > 0), 32'h1);
      repeat (17) @(posedge CLK96);
      #1;
      PAUSE      = 1'b1;
      PAUSE_MASK = 4'b0100;
      cnt = 0;
      repeat (100) begin
         @(posedge CLK96);
         @(negedge CLK96);
         if (CEN[2]) cnt++;
      end
      check("pause_no_cen", 32'(cnt), 32'd0);
      PAUSE = 1'b0;
      wait_pulse(2, 1'b0, c);
      check("pause_release_latency", 32'(c), 32'd12);

      // Reset with a pending shadow on ch0
      wait_pulse(0, 1'b0, c);
      cfg_write(2'd0, 10'd3, 10'd7);
      @(negedge CLK96);
      check("reset_pre_pending", 32'(PENDING[0]), 32'h1);
      RESET = 1'b1;
      @(posedge CLK96);
      #1 RESET = 1'b0;
      @(negedge CLK96);
      check("reset_cen", 32'(CEN), 32'h0);
      check("reset_cenb", 32'(CENB), 32'h0);
      check("reset_pending", 32'(PENDING), 32'h0);
      check("reset_cfg_err", 32'(CFG_ERR), 32'h7);
      wait_pulse(3, 1'b0, c);
      check("reset_rstcfg_ch3_first", 32'(c), 32'd3);
      cnt = 0;
      repeat (40) begin
         @(negedge CLK96);
         if (CEN[0]) cnt++;
      end
      check("reset_shadow_discarded", 32'(cnt), 32'd0);
      check("reset_no_pending", 32'(PENDING[0]), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "simulation time limit");
   end

endmodule
